fifo_wr_ptr_full: RTL and testbench

//  Write-domain control for the async FIFO: owns the binary write pointer, gates memory writes,
//  and produces FULL / ALMOST_FULL / fill level / sticky overflow. Consumes the Gray-coded read

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_wr_ptr_full_if.sv | 30 +++
 rtl/fifo_wr_ptr_full_gray_to_bin.sv | 17 +
 rtl/fifo_wr_ptr_full.sv | 66 ++++++
 tb/tb_fifo_wr_ptr_full.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray-to-binary helper
// used by both the write-side full block and the read-side empty block.
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_WIDTH = 3;
  localparam int unsigned FIFO_DEPTH      = 2 ** FIFO_ADDR_WIDTH;
  localparam int unsigned FIFO_PTR_WIDTH  = FIFO_ADDR_WIDTH + 1;

  typedef logic [FIFO_PTR_WIDTH-1:0] fifo_ptr_t;

  function automatic fifo_ptr_t gray2bin(input fifo_ptr_t g);
    fifo_ptr_t b;
    b = '0;
    for (int unsigned i = 0; i < FIFO_PTR_WIDTH; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_ptr_full_if.sv
// Write-domain bundle between the producer (master) and the write-pointer/full
// controller (slave); the synchronized read pointer travels with it.
interface fifo_wr_ptr_full_if
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
);

  logic                  W_INC;
  logic                  CLR_OVF;
  logic [ADDR_WIDTH:0]   RD_PTR_SYNC;
  logic [ADDR_WIDTH:0]   W_PTR;
  logic [ADDR_WIDTH-1:0] W_ADDR;
  logic                  W_EN;
  logic                  FULL;
  logic                  ALMOST_FULL;
  logic [ADDR_WIDTH:0]   FILL_LEVEL;
  logic                  OVERFLOW;

  modport master (
    output W_INC, CLR_OVF, RD_PTR_SYNC,
    input  W_PTR, W_ADDR, W_EN, FULL, ALMOST_FULL, FILL_LEVEL, OVERFLOW
  );

  modport slave (
    input  W_INC, CLR_OVF, RD_PTR_SYNC,
    output W_PTR, W_ADDR, W_EN, FULL, ALMOST_FULL, FILL_LEVEL, OVERFLOW
  );

endinterface

// File: rtl/fifo_wr_ptr_full_gray_to_bin.sv
// Purely combinational Gray-to-binary converter of parameterized width.
module gray_to_bin #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  // Each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    o_bin = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

// File: rtl/fifo_wr_ptr_full.sv
// Write-domain control of the async FIFO: binary write pointer, write gating,
// registered FULL / ALMOST_FULL / fill level and sticky overflow.
module fifo_wr_ptr_full
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int unsigned AF_THRESH  = 6
) (
  input  logic              CLK,
  input  logic              RST,
  fifo_wr_ptr_full_if.slave bus
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_fill;
  logic             r_full;
  logic             r_af;
  logic             r_ovf;

  logic             w_en;
  logic [PTR_W-1:0] w_rptr_bin;
  logic [PTR_W-1:0] w_next;
  logic [PTR_W-1:0] w_fill;

  gray_to_bin #(.WIDTH(PTR_W)) u_rptr_g2b (
    .i_gray (bus.RD_PTR_SYNC),
    .o_bin  (w_rptr_bin)
  );

  assign w_en   = bus.W_INC & ~r_full & RST;
  assign w_next = r_wptr + PTR_W'(w_en);
  // Flags come from the post-write pointer so a filling write blocks the very next request.
  assign w_fill = w_next - w_rptr_bin;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_wptr <= '0;
      r_fill <= '0;
      r_full <= 1'b0;
      r_af   <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_wptr <= w_next;
      r_fill <= w_fill;
      r_full <= (w_fill == PTR_W'(DEPTH));
      r_af   <= (w_fill >= PTR_W'(AF_THRESH));
      if (bus.W_INC && r_full) begin
        r_ovf <= 1'b1;
      end else if (bus.CLR_OVF) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign bus.W_PTR       = r_wptr;
  assign bus.W_ADDR      = r_wptr[ADDR_WIDTH-1:0];
  assign bus.W_EN        = w_en;
  assign bus.FULL        = r_full;
  assign bus.ALMOST_FULL = r_af;
  assign bus.FILL_LEVEL  = r_fill;
  assign bus.OVERFLOW    = r_ovf;

endmodule

// File: tb/tb_fifo_wr_ptr_full.sv
// Self-checking bench for fifo_wr_ptr_full (ADDR_WIDTH=3, AF_THRESH=6) using a
// scoreboard of predicted per-cycle snapshots.
module tb_fifo_wr_ptr_full;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  always #5 CLK = ~CLK;

  fifo_wr_ptr_full_if #(.ADDR_WIDTH(3)) bus ();

  fifo_wr_ptr_full #(.ADDR_WIDTH(3), .AF_THRESH(6)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct packed {
    logic       en;
    logic [2:0] addr;
    logic [3:0] wptr;
    logic       full;
    logic       af;
    logic [3:0] fill;
    logic       ovf;
  } snap_t;

  snap_t exp_q[$];
  snap_t obs_q[$];

  int checks   = 0;
  int failures = 0;

  logic [3:0] m_wptr = '0;
  logic [3:0] m_fill = '0;
  logic       m_full = 1'b0;
  logic       m_af   = 1'b0;
  logic       m_ovf  = 1'b0;
  int unsigned m_rd  = 0;

  // One clock cycle: drive inputs, predict, sample W_EN/W_ADDR before the edge
  // and the registered state after it.
  task automatic apply(input logic rst, input logic winc, input logic clr, input int unsigned rd);
    snap_t e;
    snap_t o;
    logic [3:0] rb;
    logic [3:0] wn;
    logic [3:0] f;
    rb = 4'(rd);
    m_rd = rd;
    RST = rst;
    bus.W_INC = winc;
    bus.CLR_OVF = clr;
    bus.RD_PTR_SYNC = rb ^ (rb >> 1);
    e.en   = rst & winc & ~m_full;
    e.addr = m_wptr[2:0];
    if (!rst) begin
      m_wptr = '0; m_fill = '0; m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
    end else begin
      wn = m_wptr + {3'b000, e.en};
      f  = wn - rb;
      if (winc && m_full) m_ovf = 1'b1;
      else if (clr)       m_ovf = 1'b0;
      m_wptr = wn;
      m_fill = f;
      m_full = (f == 4'd8);
      m_af   = (f >= 4'd6);
    end
    e.wptr = m_wptr; e.full = m_full; e.af = m_af; e.fill = m_fill; e.ovf = m_ovf;
    exp_q.push_back(e);
    #1;
    o.en   = bus.W_EN;
    o.addr = bus.W_ADDR;
    @(posedge CLK);
    #1;
    o.wptr = bus.W_PTR; o.full = bus.FULL; o.af = bus.ALMOST_FULL;
    o.fill = bus.FILL_LEVEL; o.ovf = bus.OVERFLOW;
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    snap_t e, o;
    RST = 1'b0; bus.W_INC = 1'b1; bus.CLR_OVF = 1'b0; bus.RD_PTR_SYNC = '0;
    #1;
    checks++;
    if (bus.W_EN !== 1'b0) begin
      failures++; $display("FAIL reset_wen got=%b exp=0", bus.W_EN);
    end
    @(posedge CLK); #1;
    checks++;
    if ({bus.W_PTR, bus.FULL, bus.ALMOST_FULL, bus.FILL_LEVEL, bus.OVERFLOW} !== 11'd0) begin
      failures++;
      $display("FAIL reset_state got wptr=%0d full=%b af=%b fill=%0d ovf=%b exp all 0",
               bus.W_PTR, bus.FULL, bus.ALMOST_FULL, bus.FILL_LEVEL, bus.OVERFLOW);
    end
    apply(1'b0, 1'b1, 1'b0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL reset got=%p exp=%p", o, e); end
    end
  endtask

  task automatic test_fill();
    snap_t e, o;
    for (int i = 0; i < 9; i++) apply(1'b1, 1'b1, 1'b0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL fill got=%p exp=%p", o, e); end
    end
    checks++;
    if (bus.W_PTR !== 4'd8 || bus.FILL_LEVEL !== 4'd8 || bus.FULL !== 1'b1 || bus.ALMOST_FULL !== 1'b1) begin
      failures++;
      $display("FAIL fill_final got wptr=%0d fill=%0d full=%b af=%b exp 8 8 1 1",
               bus.W_PTR, bus.FILL_LEVEL, bus.FULL, bus.ALMOST_FULL);
    end
  endtask

  task automatic test_overflow();
    snap_t e, o;
    apply(1'b1, 1'b1, 1'b0, 0);
    apply(1'b1, 1'b1, 1'b0, 0);
    checks++;
    if (bus.OVERFLOW !== 1'b1 || bus.W_PTR !== 4'd8) begin
      failures++; $display("FAIL ovf_set got ovf=%b wptr=%0d exp 1 8", bus.OVERFLOW, bus.W_PTR);
    end
    apply(1'b1, 1'b0, 1'b1, 0);
    checks++;
    if (bus.OVERFLOW !== 1'b0) begin
      failures++; $display("FAIL ovf_clr got=%b exp=0", bus.OVERFLOW);
    end
    apply(1'b1, 1'b1, 1'b1, 0);
    checks++;
    if (bus.OVERFLOW !== 1'b1) begin
      failures++; $display("FAIL ovf_set_wins got=%b exp=1", bus.OVERFLOW);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL overflow got=%p exp=%p", o, e); end
    end
  endtask

  task automatic test_release();
    snap_t e, o;
    apply(1'b1, 1'b0, 1'b1, 3);
    checks++;
    if (bus.FULL !== 1'b0 || bus.FILL_LEVEL !== 4'd5 || bus.ALMOST_FULL !== 1'b0) begin
      failures++;
      $display("FAIL release got full=%b fill=%0d af=%b exp 0 5 0",
               bus.FULL, bus.FILL_LEVEL, bus.ALMOST_FULL);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL release_sb got=%p exp=%p", o, e); end
    end
  endtask

  task automatic test_wrap();
    snap_t e, o;
    for (int k = 0; k < 6; k++) apply(1'b1, 1'b1, 1'b0, 4 + k);
    apply(1'b1, 1'b1, 1'b0, 9);
    apply(1'b1, 1'b1, 1'b0, 9);
    checks++;
    if (bus.W_PTR !== 4'd0 || bus.FILL_LEVEL !== 4'd7 || bus.FULL !== 1'b0) begin
      failures++;
      $display("FAIL wrap got wptr=%0d fill=%0d full=%b exp 0 7 0", bus.W_PTR, bus.FILL_LEVEL, bus.FULL);
    end
    apply(1'b1, 1'b1, 1'b0, 9);
    checks++;
    if (bus.W_PTR !== 4'd1 || bus.FILL_LEVEL !== 4'd8 || bus.FULL !== 1'b1) begin
      failures++;
      $display("FAIL wrap_full got wptr=%0d fill=%0d full=%b exp 1 8 1", bus.W_PTR, bus.FILL_LEVEL, bus.FULL);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL wrap_sb got=%p exp=%p", o, e); end
    end
  endtask

  task automatic test_simultaneous();
    snap_t e, o;
    apply(1'b1, 1'b0, 1'b0, 10);
    apply(1'b1, 1'b1, 1'b0, 11);
    checks++;
    if (bus.W_PTR !== 4'd2 || bus.FILL_LEVEL !== 4'd7 || bus.FULL !== 1'b0) begin
      failures++;
      $display("FAIL simult got wptr=%0d fill=%0d full=%b exp 2 7 0", bus.W_PTR, bus.FILL_LEVEL, bus.FULL);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL simult_sb got=%p exp=%p", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    snap_t e, o;
    int unsigned rd;
    logic winc;
    logic clr;
    for (int i = 0; i < 120; i++) begin
      rd = m_rd;
      if (m_fill != 0 && $urandom_range(0, 2) == 0) rd = m_rd + 1;
      winc = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 7) == 0);
      apply(1'b1, winc, clr, rd);
    end
    apply(1'b0, 1'b1, 1'b0, 0);
    apply(1'b1, 1'b1, 1'b0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL b2b got=%p exp=%p", o, e); end
    end
  endtask

  initial begin
    bus.W_INC = 1'b0;
    bus.CLR_OVF = 1'b0;
    bus.RD_PTR_SYNC = '0;
    @(posedge CLK); #1;
    test_reset();
    test_fill();
    test_overflow();
    test_release();
    test_wrap();
    test_simultaneous();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
